// File: rtl/mem_channel_arbiter.sv
// Round-robin arbiter sharing one single-ported byte memory between two master
// channels, with fixed read/write latency sequencing and per-channel completion.
module mem_channel_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int SIZE_W = 4,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            ch_oe,
  input  logic [1:0]            ch_we,
  input  logic [2*ADDR_W-1:0]   ch_addr,
  input  logic [2*DATA_W-1:0]   ch_wdata,
  input  logic [2*SIZE_W-1:0]   ch_size,
  output logic [2*DATA_W-1:0]   ch_rdata,
  output logic [1:0]            ch_rdy,
  output logic                  mem_oe,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_mask,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  err_conflict
);

  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  // Reads spend RD_LAT cycles in WAIT (capture on the last); writes one fewer.
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'((WR_LAT > 1) ? (WR_LAT - 2) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic logic [DATA_W-1:0] size_mask(input logic [SIZE_W-1:0] size);
    logic [DATA_W-1:0] m;
    m = {DATA_W{1'b0}};
    for (int b = 0; b < DATA_W; b++) begin
      m[b] = (b < int'(size)) ? 1'b1 : 1'b0;
    end
    return m;
  endfunction

  state_t              state_r;
  logic                last_grant_r;
  logic                gnt_r;
  logic                read_r;
  logic [DATA_W-1:0]   mask_r;
  logic [CNT_W-1:0]    cnt_r;

  logic [1:0]          valid_s;
  logic                conflict_s;
  logic                grant_v_s;
  logic                grant_ch_s;
  logic                sel_oe_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic [DATA_W-1:0]   sel_mask_s;

  assign valid_s    = ch_oe ^ ch_we;
  assign conflict_s = |(ch_oe & ch_we);

  // Grant decision: a lone valid request wins, a tie goes away from last_grant.
  always_comb begin
    grant_v_s  = 1'b0;
    grant_ch_s = 1'b0;
    case (valid_s)
      2'b01: begin
        grant_v_s  = 1'b1;
        grant_ch_s = 1'b0;
      end
      2'b10: begin
        grant_v_s  = 1'b1;
        grant_ch_s = 1'b1;
      end
      2'b11: begin
        grant_v_s  = 1'b1;
        grant_ch_s = ~last_grant_r;
      end
      default: begin
        grant_v_s  = 1'b0;
        grant_ch_s = 1'b0;
      end
    endcase
  end

  // Field mux for the candidate channel.
  always_comb begin
    if (grant_ch_s) begin
      sel_oe_s    = ch_oe[1];
      sel_addr_s  = ch_addr[2*ADDR_W-1:ADDR_W];
      sel_wdata_s = ch_wdata[2*DATA_W-1:DATA_W];
      sel_mask_s  = size_mask(ch_size[2*SIZE_W-1:SIZE_W]);
    end else begin
      sel_oe_s    = ch_oe[0];
      sel_addr_s  = ch_addr[ADDR_W-1:0];
      sel_wdata_s = ch_wdata[DATA_W-1:0];
      sel_mask_s  = size_mask(ch_size[SIZE_W-1:0]);
    end
  end

  // Transaction FSM with registered memory strobes and channel responses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      gnt_r        <= 1'b0;
      read_r       <= 1'b0;
      mask_r       <= {DATA_W{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      mem_oe       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= {ADDR_W{1'b0}};
      mem_wdata    <= {DATA_W{1'b0}};
      mem_mask     <= {DATA_W{1'b0}};
      ch_rdy       <= 2'b00;
      ch_rdata     <= {(2*DATA_W){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          ch_rdy <= 2'b00;
          if (grant_v_s) begin
            gnt_r        <= grant_ch_s;
            last_grant_r <= grant_ch_s;
            read_r       <= sel_oe_s;
            mask_r       <= sel_mask_s;
            mem_oe       <= sel_oe_s;
            mem_we       <= ~sel_oe_s;
            mem_addr     <= sel_addr_s;
            mem_wdata    <= sel_oe_s ? {DATA_W{1'b0}} : sel_wdata_s;
            mem_mask     <= sel_mask_s;
            state_r      <= ISSUE;
          end
        end
        ISSUE: begin
          mem_oe    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= {ADDR_W{1'b0}};
          mem_wdata <= {DATA_W{1'b0}};
          mem_mask  <= {DATA_W{1'b0}};
          if (read_r) begin
            cnt_r   <= RD_LOAD;
            state_r <= WAIT;
          end else if (WR_LAT == 1) begin
            ch_rdy  <= gnt_r ? 2'b10 : 2'b01;
            state_r <= RESP;
          end else begin
            cnt_r   <= WR_LOAD;
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            if (read_r) begin
              if (gnt_r) begin
                ch_rdata[2*DATA_W-1:DATA_W] <= mem_rdata & mask_r;
              end else begin
                ch_rdata[DATA_W-1:0] <= mem_rdata & mask_r;
              end
            end
            ch_rdy  <= gnt_r ? 2'b10 : 2'b01;
            state_r <= RESP;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        RESP: begin
          ch_rdy  <= 2'b00;
          state_r <= IDLE;
        end
        default: begin
          ch_rdy  <= 2'b00;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Sticky flag for a channel asserting read and write at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_conflict <= 1'b0;
    end else if (conflict_s) begin
      err_conflict <= 1'b1;
    end
  end

endmodule
